display_readback: RTL

- Read-side responder for the display peripheral: services CPU load requests into the display address space, the counterpart to the framebuffer write path.
- Region 4'h1 (raddr[31:28]): framebuffer byte readback through the framebuffer's second read port.
- Region 4'h2: frame status word, giving the CPU vblank sync without polling raw timing.
- Sits beside the VGA sync generator and the framebuffer on the same system clock.

---
 rtl/display_readback.sv | 134 +++++++++++++
 1 files changed

// File: rtl/display_readback.sv
// display_readback: read-side responder for the display address space.
//   Region 4'h1 (raddr[31:28]) reads framebuffer bytes through the second
//   BRAM read port. Region 4'h2 returns the frame status word
//   {frame_count, 14'b0, in_vblank, vblank_sticky}. All other regions read 0.
// Optional feature macro: READBACK_ERR_EN adds an err flag, valid with r_valid.
//
// Handshake: a request is accepted on a clk edge where r_req=1 and busy=0.
// Exactly one r_valid pulse follows each accepted request. rdata (and err)
// change only on the edge that enters RESP and hold until the next response.
// r_req seen while busy=1 is dropped, not queued.
module display_readback #(
  parameter int unsigned FB_DEPTH     = 307200,
  parameter bit          VSYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr,
  input  logic        r_req,
  output logic        busy,
  output logic        r_valid,
  output logic [31:0] rdata,
  output logic        fb_ren,
  output logic [18:0] fb_raddr,
  input  logic [7:0]  fb_rdata,
  input  logic        vsync,
  input  logic        video_on,
`ifdef READBACK_ERR_EN
  output logic        err,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FB_RD   = 2'd1,
    FB_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        in_range;
  logic        fb_hit;
  logic        status_hit;
  logic        vsync_q;
  logic        vsync_edge;
  logic [15:0] frame_count;
  logic        vblank_sticky;
  logic        in_vblank;
  logic [31:0] status_word;
  logic        unused_raddr;

  // Address bits between the region nibble and the byte offset are don't-care.
  assign unused_raddr = ^raddr[27:19];

  assign accept      = (state == IDLE) && r_req;
  assign in_range    = {13'b0, raddr[18:0]} < FB_DEPTH;
  assign fb_hit      = (raddr[31:28] == 4'h1) && in_range;
  assign status_hit  = (raddr[31:28] == 4'h2);
  assign vsync_edge  = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
  assign status_word = {frame_count, 14'b0, in_vblank, vblank_sticky};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state: only in-range framebuffer reads take the BRAM path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (r_req) state_next = fb_hit ? FB_RD : RESP;
      FB_RD:   state_next = FB_WAIT;
      FB_WAIT: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: strobes are pure functions of the current state.
  always_comb begin
    busy      = (state != IDLE);
    r_valid   = (state == RESP);
    fb_ren    = (state == FB_RD);
    state_dbg = state;
  end

  // Response datapath: BRAM address at accept, data on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata    <= 32'h0;
      fb_raddr <= 19'h0;
    end else begin
      if (accept) begin
        if (fb_hit) fb_raddr <= raddr[18:0];
        else        rdata    <= status_hit ? status_word : 32'h0;
      end
      if (state == FB_WAIT) rdata <= {24'b0, fb_rdata};
    end
  end

`ifdef READBACK_ERR_EN
  // Error flag: out-of-range framebuffer and unmapped regions report err=1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      if (accept && !fb_hit) err <= !status_hit;
      if (state == FB_WAIT)  err <= 1'b0;
    end
  end
`endif

  // Frame tracking: a vsync-assert edge beats a same-edge status-read clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vsync_q       <= !VSYNC_ACTIVE;
      frame_count   <= 16'h0;
      vblank_sticky <= 1'b0;
      in_vblank     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync_edge) frame_count <= frame_count + 16'd1;
      if (vsync_edge)                   vblank_sticky <= 1'b1;
      else if (accept && status_hit)    vblank_sticky <= 1'b0;
      if (vsync_edge)    in_vblank <= 1'b1;
      else if (video_on) in_vblank <= 1'b0;
    end
  end

endmodule
